// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic-light lamp stage: signal codes, fault causes,
// monitor states and the per-approach code extractor.
package traffic_pkg;

    localparam int NUM_APPR = 4;

    localparam logic [1:0] CODE_R   = 2'b00;
    localparam logic [1:0] CODE_Y   = 2'b01;
    localparam logic [1:0] CODE_G   = 2'b10;
    localparam logic [1:0] CODE_ILL = 2'b11;

    localparam logic [2:0] FLT_NONE         = 3'd0;
    localparam logic [2:0] FLT_ILLEGAL      = 3'd1;
    localparam logic [2:0] FLT_MULTI_GREEN  = 3'd2;
    localparam logic [2:0] FLT_GREEN_YELLOW = 3'd3;
    localparam logic [2:0] FLT_STALL        = 3'd4;

    typedef enum logic {
        ST_NORMAL = 1'b0,
        ST_FAULT  = 1'b1
    } state_t;

    function automatic logic [1:0] appr_code(input logic [2*NUM_APPR-1:0] word, input int idx);
        return word[2*idx +: 2];
    endfunction

endpackage

// File: rtl/lamp_blink_gen.sv
// Flash timing for the all-yellow fault display: phase flips every BLINK_DIV clocks
// while enabled; a clear restarts the count with the phase on.
module lamp_blink_gen #(
    parameter int BLINK_DIV = 50_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_phase,
    output logic o_tick
);

    localparam int CNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_DIV - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_phase;

    // o_tick marks the clock on which the phase will flip, so callers can register the next phase.
    assign o_tick  = i_en && (r_cnt == CNT_LAST);
    assign o_phase = r_phase;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_phase <= 1'b1;
        end else if (i_clr) begin
            r_cnt   <= '0;
            r_phase <= 1'b1;
        end else if (i_en) begin
            if (o_tick) begin
                r_cnt   <= '0;
                r_phase <= ~r_phase;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/signal_lamp_monitor.sv
// Lamp driver and conflict monitor behind the traffic sequencer: decodes the packed signal
// word to R/Y/G lamps and latches a flashing-yellow fault on illegal, conflicting or stalled input.
//
// state     | meaning
// ST_NORMAL | lamps follow the registered signal word
// ST_FAULT  | all-yellow flash, first cause held until a clear with a clean word
module signal_lamp_monitor
    import traffic_pkg::*;
#(
    parameter int WDOG_CYCLES = 1_000_000,
    parameter int BLINK_DIV   = 50_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] signal_in,
    input  logic       fault_clr,
    output logic [3:0] lamp_r,
    output logic [3:0] lamp_y,
    output logic [3:0] lamp_g,
    output logic       fault,
    output logic [2:0] fault_code
);

    localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYCLES - 1);

    logic [7:0]        r_sig_q;
    logic [WDOG_W-1:0] r_wdog;
    state_t            r_state;
    state_t            w_state_nxt;
    logic [3:0]        r_lamp_r, r_lamp_y, r_lamp_g;
    logic [2:0]        r_fault_code;

    logic [3:0] w_dec_r, w_dec_y, w_dec_g;
    logic [2:0] w_n_green, w_n_yel;
    logic       w_any_ill, w_multi_green, w_green_yellow, w_word_bad, w_stall;
    logic [2:0] w_cause;
    logic       w_enter, w_exit;
    logic       w_phase, w_tick, w_phase_nxt;
    logic [3:0] w_lamp_r_d, w_lamp_y_d, w_lamp_g_d;
    logic [2:0] w_code_d;

    always_ff @(posedge clk) begin
        if (!rst_n) r_sig_q <= 8'h00;
        else        r_sig_q <= signal_in;
    end

    // wdog counts edges since sig_q last changed, so it sits at WDOG_LAST once sig_q
    // has been visible unchanged for WDOG_CYCLES clocks.
    always_ff @(posedge clk) begin
        if (!rst_n)                      r_wdog <= '0;
        else if (w_exit)                 r_wdog <= '0;
        else if (signal_in != r_sig_q)   r_wdog <= '0;
        else if (r_wdog != WDOG_LAST)    r_wdog <= r_wdog + WDOG_W'(1);
    end

    always_comb begin
        w_dec_r   = '0;
        w_dec_y   = '0;
        w_dec_g   = '0;
        w_n_green = '0;
        w_n_yel   = '0;
        w_any_ill = 1'b0;
        for (int i = 0; i < NUM_APPR; i++) begin
            case (appr_code(r_sig_q, i))
                CODE_R: w_dec_r[i] = 1'b1;
                CODE_Y: begin
                    w_dec_y[i] = 1'b1;
                    w_n_yel    = w_n_yel + 3'd1;
                end
                CODE_G: begin
                    w_dec_g[i] = 1'b1;
                    w_n_green  = w_n_green + 3'd1;
                end
                CODE_ILL: w_any_ill = 1'b1;
                default:  w_any_ill = 1'b1;
            endcase
        end
    end

    assign w_multi_green  = (w_n_green >= 3'd2);
    assign w_green_yellow = (w_n_green == 3'd1) && (w_n_yel != 3'd0);
    assign w_word_bad     = w_any_ill || w_multi_green || w_green_yellow;
    assign w_stall        = (r_wdog == WDOG_LAST);

    always_comb begin
        w_cause = FLT_NONE;
        if (w_any_ill)           w_cause = FLT_ILLEGAL;
        else if (w_multi_green)  w_cause = FLT_MULTI_GREEN;
        else if (w_green_yellow) w_cause = FLT_GREEN_YELLOW;
        else if (w_stall)        w_cause = FLT_STALL;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= ST_NORMAL;
        else        r_state <= w_state_nxt;
    end

    // A stalled-but-clean word may be cleared; only checks on the word content block the exit.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_NORMAL: if (w_cause != FLT_NONE)        w_state_nxt = ST_FAULT;
            ST_FAULT:  if (fault_clr && !w_word_bad)   w_state_nxt = ST_NORMAL;
            default:                                   w_state_nxt = ST_NORMAL;
        endcase
    end

    assign w_enter = (r_state == ST_NORMAL) && (w_state_nxt == ST_FAULT);
    assign w_exit  = (r_state == ST_FAULT)  && (w_state_nxt == ST_NORMAL);

    lamp_blink_gen #(
        .BLINK_DIV (BLINK_DIV)
    ) u_blink (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clr   (w_enter),
        .i_en    (r_state == ST_FAULT),
        .o_phase (w_phase),
        .o_tick  (w_tick)
    );

    assign w_phase_nxt = w_tick ? ~w_phase : w_phase;

    // Lamps are driven from the next state so a faulty word is never displayed.
    always_comb begin
        w_lamp_r_d = '0;
        w_lamp_y_d = '0;
        w_lamp_g_d = '0;
        w_code_d   = r_fault_code;
        if (w_state_nxt == ST_NORMAL) begin
            w_lamp_r_d = w_dec_r;
            w_lamp_y_d = w_dec_y;
            w_lamp_g_d = w_dec_g;
            w_code_d   = FLT_NONE;
        end else if (w_enter) begin
            w_lamp_y_d = 4'hF;
            w_code_d   = w_cause;
        end else begin
            w_lamp_y_d = {4{w_phase_nxt}};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_lamp_r     <= 4'hF;
            r_lamp_y     <= 4'h0;
            r_lamp_g     <= 4'h0;
            r_fault_code <= FLT_NONE;
        end else begin
            r_lamp_r     <= w_lamp_r_d;
            r_lamp_y     <= w_lamp_y_d;
            r_lamp_g     <= w_lamp_g_d;
            r_fault_code <= w_code_d;
        end
    end

    assign lamp_r     = r_lamp_r;
    assign lamp_y     = r_lamp_y;
    assign lamp_g     = r_lamp_g;
    assign fault      = (r_state == ST_FAULT);
    assign fault_code = r_fault_code;

endmodule
